// File: rtl/arb_req_client_if.sv
// Bundled producer, arbiter and bus signals for arb_req_client.
// Optional grant_count signal present when ARB_REQ_CLIENT_GRANT_CNT_EN is defined.
interface arb_req_client_if #(
    parameter int DataWidth = 32
);
    logic                 in_valid;
    logic [DataWidth-1:0] in_data;
    logic                 in_ready;
    logic                 req_out;
    logic                 grant_in;
    logic                 bus_valid;
    logic [DataWidth-1:0] bus_data;
    logic                 starve_out;
    logic                 spurious_grant;
`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
    logic [15:0]          grant_count;
`endif

    modport master (
        output in_valid, in_data, grant_in,
        input  in_ready, req_out, bus_valid, bus_data, starve_out, spurious_grant
`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
        , input grant_count
`endif
    );

    modport slave (
        input  in_valid, in_data, grant_in,
        output in_ready, req_out, bus_valid, bus_data, starve_out, spurious_grant
`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
        , output grant_count
`endif
    );
endinterface

// File: rtl/arb_req_client.sv
// Requester endpoint for round-robin req/grant arbiters: FIFO, request FSM, starvation flag.
// Define ARB_REQ_CLIENT_GRANT_CNT_EN to add a 16-bit wrapping accepted-grant counter.
module arb_req_client #(
    parameter int DataWidth   = 32,
    parameter int Depth       = 4,
    parameter int WaitWidth   = 8,
    parameter int StarveLimit = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    arb_req_client_if.slave      bus
);
    localparam int PW = $clog2(Depth);
    localparam int CW = $clog2(Depth) + 1;
    localparam logic [CW-1:0]        DEPTH_C = CW'(Depth);
    localparam logic [WaitWidth-1:0] LIMIT_C = WaitWidth'(StarveLimit);

    typedef enum logic {IDLE, REQ} state_t;

    state_t               r_state;
    logic [DataWidth-1:0] r_mem [Depth];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;
    logic [WaitWidth-1:0] r_wait;
    logic                 r_bus_valid;
    logic [DataWidth-1:0] r_bus_data;
    logic                 r_starve;
    logic                 r_spurious;

    logic                 w_push;
    logic                 w_grant;
    logic [CW-1:0]        w_count_next;
    logic [WaitWidth-1:0] w_wait_next;

    // Full blocks pushes outright, even when a pop lands in the same cycle.
    assign bus.in_ready = (r_count < DEPTH_C);
    assign w_push       = bus.in_valid && bus.in_ready;
    assign w_grant      = (r_state == REQ) && bus.grant_in;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_grant);

    always_comb begin
        w_wait_next = '0;
        if (r_state == REQ && !w_grant) begin
            w_wait_next = (r_wait == '1) ? r_wait : r_wait + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wait      <= '0;
            r_bus_valid <= 1'b0;
            r_bus_data  <= '0;
            r_starve    <= 1'b0;
            r_spurious  <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_wait      <= w_wait_next;
            r_starve    <= (w_wait_next >= LIMIT_C);
            r_bus_valid <= w_grant;
            r_spurious  <= bus.grant_in && (r_state != REQ);
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_grant) begin
                r_bus_data <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + 1'b1;
            end
            case (r_state)
                IDLE: if (r_count != '0) r_state <= REQ;
                REQ:  if (w_grant && w_count_next == '0) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_out        = (r_state == REQ);
    assign bus.bus_valid      = r_bus_valid;
    assign bus.bus_data       = r_bus_data;
    assign bus.starve_out     = r_starve;
    assign bus.spurious_grant = r_spurious;

`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
    logic [15:0] r_grant_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt <= '0;
        end else if (w_grant) begin
            r_grant_cnt <= r_grant_cnt + 16'd1;
        end
    end

    assign bus.grant_count = r_grant_cnt;
`endif
endmodule

// File: tb/tb_arb_req_client.sv
// Scoreboard bench for arb_req_client: expected issues queued by stimulus, popped by a bus monitor.
module tb_arb_req_client;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] exp_q [$];

    arb_req_client_if #(.DataWidth(32)) ifc ();

    arb_req_client #(
        .DataWidth(32),
        .Depth(4),
        .WaitWidth(8),
        .StarveLimit(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every issue strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst && ifc.bus_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_issue: got 0x%08h expected no issue at %0t", ifc.bus_data, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (ifc.bus_data !== e) begin
                    errors++;
                    $display("FAIL bus_issue: got 0x%08h expected 0x%08h at %0t", ifc.bus_data, e, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        ifc.grant_in = 1'b0;
        repeat (2) step();
        chk("rst_req", 32'(ifc.req_out), 32'd0);
        chk("rst_bus_valid", 32'(ifc.bus_valid), 32'd0);
        chk("rst_bus_data", ifc.bus_data, 32'd0);
        chk("rst_starve", 32'(ifc.starve_out), 32'd0);
        chk("rst_spurious", 32'(ifc.spurious_grant), 32'd0);
        chk("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Single transaction latency
        ifc.in_valid = 1'b1; ifc.in_data = 32'hA5A5_0001;
        step();
        ifc.in_valid = 1'b0;
        chk("t1_req_after_E0", 32'(ifc.req_out), 32'd0);
        step();
        chk("t1_req_after_E1", 32'(ifc.req_out), 32'd1);
        ifc.grant_in = 1'b1; exp_q.push_back(32'hA5A5_0001);
        step();
        ifc.grant_in = 1'b0;
        chk("t1_bus_valid", 32'(ifc.bus_valid), 32'd1);
        chk("t1_req_dropped", 32'(ifc.req_out), 32'd0);
        step();
        chk("t1_bus_valid_pulse", 32'(ifc.bus_valid), 32'd0);

        // Fill to full, refused fifth push, then back-to-back drain
        for (int i = 1; i <= 4; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 32'(i);
            step();
        end
        chk("t2_full_in_ready", 32'(ifc.in_ready), 32'd0);
        ifc.in_data = 32'd5;
        step();
        ifc.in_valid = 1'b0;
        chk("t2_still_full", 32'(ifc.in_ready), 32'd0);
        chk("t2_req_high", 32'(ifc.req_out), 32'd1);
        ifc.grant_in = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'(i));
            step();
            chk("t2_drain_valid", 32'(ifc.bus_valid), 32'd1);
        end
        ifc.grant_in = 1'b0;
        chk("t2_req_dropped", 32'(ifc.req_out), 32'd0);
        chk("t2_in_ready", 32'(ifc.in_ready), 32'd1);
        step();
        chk("t2_no_fifth", 32'(ifc.bus_valid), 32'd0);

        // Starvation threshold
        ifc.in_valid = 1'b1; ifc.in_data = 32'h0000_0033;
        step();
        ifc.in_valid = 1'b0;
        step();
        repeat (15) step();
        chk("t3_starve_15", 32'(ifc.starve_out), 32'd0);
        step();
        chk("t3_starve_16", 32'(ifc.starve_out), 32'd1);
        repeat (4) step();
        chk("t3_starve_20", 32'(ifc.starve_out), 32'd1);
        ifc.grant_in = 1'b1; exp_q.push_back(32'h0000_0033);
        step();
        ifc.grant_in = 1'b0;
        chk("t3_starve_cleared", 32'(ifc.starve_out), 32'd0);
        chk("t3_req_dropped", 32'(ifc.req_out), 32'd0);

        // Spurious grant in IDLE
        step();
        ifc.grant_in = 1'b1;
        step();
        ifc.grant_in = 1'b0;
        chk("t4_spurious", 32'(ifc.spurious_grant), 32'd1);
        chk("t4_no_issue", 32'(ifc.bus_valid), 32'd0);
        chk("t4_req_low", 32'(ifc.req_out), 32'd0);
        step();
        chk("t4_spurious_pulse", 32'(ifc.spurious_grant), 32'd0);
        chk("t4_req_still_low", 32'(ifc.req_out), 32'd0);

        // Grant and push together with one entry queued
        ifc.in_valid = 1'b1; ifc.in_data = 32'h0000_0051;
        step();
        ifc.in_valid = 1'b0;
        step();
        ifc.grant_in = 1'b1; ifc.in_valid = 1'b1; ifc.in_data = 32'h0000_0052;
        exp_q.push_back(32'h0000_0051);
        step();
        ifc.grant_in = 1'b0; ifc.in_valid = 1'b0;
        chk("t5_req_kept", 32'(ifc.req_out), 32'd1);
        step();
        chk("t5_req_still", 32'(ifc.req_out), 32'd1);
        ifc.grant_in = 1'b1; exp_q.push_back(32'h0000_0052);
        step();
        ifc.grant_in = 1'b0;
        chk("t5_req_dropped", 32'(ifc.req_out), 32'd0);

        // Asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) begin
            ifc.in_valid = 1'b1; ifc.in_data = 32'h0000_0061 + 32'(i);
            step();
        end
        ifc.in_valid = 1'b0;
        step();
        ifc.grant_in = 1'b1; exp_q.push_back(32'h0000_0061);
        step();
        ifc.grant_in = 1'b0;
`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
        chk("t6_grant_count", 32'(ifc.grant_count), 32'd9);
`endif
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_req", 32'(ifc.req_out), 32'd0);
        chk("t6_rst_bus_valid", 32'(ifc.bus_valid), 32'd0);
        chk("t6_rst_bus_data", ifc.bus_data, 32'd0);
        step();
        rst = 1'b0;
        chk("t6_in_ready", 32'(ifc.in_ready), 32'd1);
`ifdef ARB_REQ_CLIENT_GRANT_CNT_EN
        chk("t6_grant_count_rst", 32'(ifc.grant_count), 32'd0);
`endif
        repeat (3) step();
        chk("t6_discarded", 32'(ifc.req_out), 32'd0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
